// File: rtl/fb_scanout.sv
// Framebuffer scanout reader: fetches the palette-indexed frame from DDRAM one 64-bit word at a
// time into a small FIFO and emits one palette index per active pixel.
module fb_scanout #(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 480,
  parameter logic [28:0] BASE   = 29'h0600_0000,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        ce_pix,
  input  logic        de,
  output logic        rd_req,
  output logic [28:0] rd_addr,
  input  logic        rd_ready,
  input  logic [63:0] rd_data,
  output logic [7:0]  pix_index,
  output logic        pix_valid,
  output logic        underflow
);

  localparam int unsigned NWORDS = WIDTH * HEIGHT / 8;
  localparam int unsigned CW     = $clog2(NWORDS + 1);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned AW1    = AW + 1;
  localparam logic [CW-1:0] NW   = CW'(NWORDS);
  localparam logic [AW:0]   FULL = AW1'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e          r_state;
  state_e          w_next_state;
  logic [CW-1:0]   r_fetch_cnt;
  logic            r_armed;
  logic [28:0]     r_rd_addr;

  logic [63:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic [2:0]      r_byte_ptr;
  logic [7:0]      r_pix_index;
  logic            r_pix_valid;
  logic            r_underflow;

  logic            w_push;
  logic            w_pop;
  logic            w_start_fetch;
  logic            w_can_fetch;
  logic            w_consume;
  logic            w_empty;
  logic [63:0]     w_head;
  logic [7:0]      w_byte;

  assign w_empty     = (r_count == '0);
  assign w_consume   = ce_pix & de;
  // Nothing is fetched after reset until the first frame_start aligns us to a frame.
  assign w_can_fetch = r_armed && (r_fetch_cnt < NW) && (r_count < FULL);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_byte      = w_head[{r_byte_ptr, 3'b000} +: 8];
  assign w_pop       = !frame_start && w_consume && !w_empty && (r_byte_ptr == 3'd7);

  always_comb begin
    w_next_state  = r_state;
    w_push        = 1'b0;
    w_start_fetch = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!frame_start && w_can_fetch) begin
          w_next_state  = StFetch;
          w_start_fetch = 1'b1;
        end
      end
      StFetch: begin
        // A response landing with frame_start belongs to the old frame: drop it, no drain needed.
        if (frame_start) begin
          w_next_state = rd_ready ? StIdle : StDrain;
        end else if (rd_ready) begin
          w_push       = 1'b1;
          w_next_state = StIdle;
        end
      end
      StDrain: begin
        if (rd_ready) begin
          w_next_state = StIdle;
        end
      end
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_fetch_cnt <= '0;
      r_armed     <= 1'b0;
      r_rd_addr   <= BASE;
    end else begin
      r_state <= w_next_state;
      if (frame_start) begin
        r_fetch_cnt <= '0;
        r_armed     <= 1'b1;
      end else if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + CW'(1);
      end
      // Address is latched so it stays put through a drain after fetch_cnt is cleared.
      if (w_start_fetch) begin
        r_rd_addr <= BASE + 29'(r_fetch_cnt);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rd_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (frame_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + AW1'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - AW1'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_ptr  <= 3'd0;
      r_pix_index <= 8'h00;
      r_pix_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else if (frame_start) begin
      r_byte_ptr  <= 3'd0;
      r_pix_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_consume) begin
      if (!w_empty) begin
        r_pix_index <= w_byte;
        r_pix_valid <= 1'b1;
        r_byte_ptr  <= r_byte_ptr + 3'd1;
      end else begin
        // Starved pixel is dropped; the pointer stays so no data is skipped.
        r_pix_index <= 8'h00;
        r_pix_valid <= 1'b0;
        r_underflow <= 1'b1;
      end
    end else begin
      r_pix_valid <= 1'b0;
    end
  end

  assign rd_req    = (r_state != StIdle);
  assign rd_addr   = r_rd_addr;
  assign pix_index = r_pix_index;
  assign pix_valid = r_pix_valid;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced 32x8 frame (32 words) with a latency-programmable
// DDRAM read responder.
module tb_fb_scanout;

  localparam logic [28:0] BASE_A = 29'h0600_0000;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        ce_pix;
  logic        de;
  logic        rd_req;
  logic [28:0] rd_addr;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic [7:0]  pix_index;
  logic        pix_valid;
  logic        underflow;

  int n_checks  = 0;
  int n_fail    = 0;
  int req_total = 0;
  int mem_lat   = 3;
  int mem_mode  = 0;
  int base;
  logic req_prev = 1'b0;

  fb_scanout #(
    .WIDTH (32),
    .HEIGHT(8),
    .BASE  (BASE_A),
    .DEPTH (16)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .ce_pix     (ce_pix),
    .de         (de),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .pix_index  (pix_index),
    .pix_valid  (pix_valid),
    .underflow  (underflow)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [63:0] gen_word(input int md, input logic [28:0] addr);
    logic [28:0] k;
    logic [63:0] w;
    k = addr - BASE_A;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      case (md)
        0:       w[j*8 +: 8] = k[7:0];
        1:       w[j*8 +: 8] = 8'(j);
        default: w[j*8 +: 8] = {k[4:0], 3'(j)};
      endcase
    end
    return w;
  endfunction

  // Read responder: answers a held request after mem_lat cycles with a one-cycle rd_ready.
  initial begin
    int cnt;
    cnt      = 0;
    rd_ready = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (rd_ready) begin
        rd_ready = 1'b0;
        cnt      = 0;
      end else if (rd_req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          rd_ready = 1'b1;
          rd_data  = gen_word(mem_mode, rd_addr);
          cnt      = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(posedge clk_sys) begin
    #2;
    if (rd_req && !req_prev) req_total++;
    req_prev = rd_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk_sys);
    frame_start = 1'b0;
  endtask

  task automatic consume(input int n);
    ce_pix = 1'b1;
    de     = 1'b1;
    repeat (n) @(negedge clk_sys);
    ce_pix = 1'b0;
    de     = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input int max, input string tag);
    for (int i = 0; i < max && rd_req !== lvl; i++) @(negedge clk_sys);
    check(tag, rd_req, lvl);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    ce_pix      = 1'b0;
    de          = 1'b0;
    tick(3);

    // Reset values and no fetching before the first frame_start
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, BASE_A);
    check("rst_pix_index", pix_index, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_underflow", underflow, 0);
    rst_n = 1'b1;
    tick(5);
    check("idle_before_start", rd_req, 0);
    check("reqs_before_start", req_total, 0);

    // Fill: 16 requests from BASE, then idle until a slot frees
    base = req_total;
    pulse_start();
    wait_req(1'b1, 10, "t1_req_rise");
    check("t1_first_addr", rd_addr, BASE_A);
    tick(200);
    check("t1_fill_reqs", req_total - base, 16);
    check("t1_req_low_full", rd_req, 0);
    consume(9);
    check("t1_pix9", {pix_valid, pix_index}, {1'b1, 8'h01});
    tick(1);
    check("t1_valid_clear", pix_valid, 0);
    check("t1_index_hold", pix_index, 8'h01);
    tick(20);
    check("t1_refill_req", req_total - base, 17);

    // Whole frame, bytes 0..7 in every word
    mem_mode = 1;
    pulse_start();
    base = req_total;
    tick(100);
    ce_pix = 1'b1;
    de     = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_sys);
      check("t2_pix", {pix_valid, pix_index}, {1'b1, 8'(i % 8)});
    end
    ce_pix = 1'b0;
    de     = 1'b0;
    check("t2_no_underflow", underflow, 0);
    check("t2_last_addr", rd_addr, BASE_A + 29'd31);
    check("t2_frame_reqs", req_total - base, 32);
    check("t2_req_low_done", rd_req, 0);
    consume(1);
    check("t2_past_end_pix", {pix_valid, pix_index}, 9'h000);
    check("t2_past_end_uflow", underflow, 1);

    // Long memory latency starves the pixel stream
    mem_lat  = 40;
    mem_mode = 0;
    pulse_start();
    ce_pix = 1'b1;
    de     = 1'b1;
    tick(5);
    check("t3_uflow", underflow, 1);
    check("t3_starved_pix", {pix_valid, pix_index}, 9'h000);
    for (int i = 0; i < 80 && pix_valid !== 1'b1; i++) @(negedge clk_sys);
    check("t3_first_valid", {pix_valid, pix_index}, {1'b1, 8'h00});
    tick(12);
    check("t3_starved_again", pix_valid, 0);
    check("t3_uflow_sticky", underflow, 1);
    ce_pix = 1'b0;
    de     = 1'b0;
    pulse_start();
    check("t3_uflow_cleared", underflow, 0);
    mem_lat = 8;
    tick(60);

    // frame_start mid-fetch: drain the in-flight word, restart at BASE
    pulse_start();
    for (int i = 0; i < 200 && !(rd_req === 1'b1 && rd_addr === BASE_A + 29'd3); i++)
      @(negedge clk_sys);
    check("t4_req3_addr", rd_addr, BASE_A + 29'd3);
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("t4_drain_req", rd_req, 1);
    check("t4_drain_addr", rd_addr, BASE_A + 29'd3);
    wait_req(1'b0, 20, "t4_drain_done");
    wait_req(1'b1, 10, "t4_next_req");
    check("t4_restart_addr", rd_addr, BASE_A);
    tick(80);
    consume(1);
    check("t4_first_pix", {pix_valid, pix_index}, {1'b1, 8'h00});

    // frame_start coincident with rd_ready and an enabled pixel
    mem_lat  = 3;
    mem_mode = 2;
    pulse_start();
    tick(120);
    consume(11);
    for (int i = 0; i < 20 && rd_ready !== 1'b1; i++) @(negedge clk_sys);
    check("t5_ready_seen", rd_ready, 1);
    frame_start = 1'b1;
    ce_pix      = 1'b1;
    de          = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
    ce_pix = 1'b0;
    de     = 1'b0;
    check("t5_empty_pix", pix_valid, 0);
    check("t5_empty_uflow", underflow, 1);
    wait_req(1'b1, 10, "t5_req");
    check("t5_restart_addr", rd_addr, BASE_A);
    tick(80);
    consume(1);
    check("t5_pix0", {pix_valid, pix_index}, {1'b1, 8'h00});
    consume(1);
    check("t5_pix1", {pix_valid, pix_index}, {1'b1, 8'h01});

    // Asynchronous reset mid-frame with a request outstanding
    mem_mode = 0;
    pulse_start();
    consume(1);
    check("t6_uflow_set", underflow, 1);
    tick(100);
    consume(9);
    check("t6_pix9", {pix_valid, pix_index}, {1'b1, 8'h01});
    wait_req(1'b1, 20, "t6_req_high");
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd_req", rd_req, 0);
    check("t6_rst_rd_addr", rd_addr, BASE_A);
    check("t6_rst_pix_index", pix_index, 0);
    check("t6_rst_pix_valid", pix_valid, 0);
    check("t6_rst_underflow", underflow, 0);
    tick(2);
    rst_n = 1'b1;
    base  = req_total;
    tick(20);
    check("t6_idle_after_rst", rd_req, 0);
    check("t6_no_reqs_after_rst", req_total - base, 0);
    pulse_start();
    wait_req(1'b1, 10, "t6_req_after_start");
    check("t6_addr_after_start", rd_addr, BASE_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
